// File: rtl/led_bar_pkg.sv
// Shared types and sizing helpers for the LED bar-graph driver.
// Latency: n/a (package only).
// Backpressure: n/a.
package led_bar_pkg;

  // Bar controller operating modes.
  typedef enum logic [1:0] {
    S_STEADY = 2'd0,
    S_RAMP   = 2'd1,
    S_BLINK  = 2'd2
  } state_t;

  // Number of level steps the bar can show.
  function automatic int max_level(input int led_num, input int seg);
    return led_num / seg;
  endfunction

  // Bits needed to hold a displayed level in 0..max_lvl.
  function automatic int level_width(input int max_lvl);
    return (max_lvl < 1) ? 1 : $clog2(max_lvl + 1);
  endfunction

endpackage

// File: rtl/led_bar_ctrl_tick_gen.sv
// Periodic strobe: one-cycle tick every DIV enabled cycles (DIV=1 ticks every cycle).
// Latency: tick is combinational from the counter; count restarts from 0 while en is low.
// Backpressure: none, free-running whenever enabled.
module tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  // Count enabled cycles, wrapping at DIV-1 and holding at zero while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_bar_ctrl.sv
// LED bar-graph driver: ramps the lit bar toward the requested level, blinks on over-range, PWM dims.
// Latency: one register stage from internal state / PWM counter to led.
// Backpressure: none; level and brightness are sampled every cycle, intermediate requests are dropped.
module led_bar_ctrl
  import led_bar_pkg::*;
#(
  parameter int LED_NUM   = 16,
  parameter int SEG       = 4,
  parameter int LEVEL_W   = 4,
  parameter int RAMP_DIV  = 25_000_000,
  parameter int BLINK_DIV = 50_000_000,
  parameter int PWM_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] level,
  input  logic [PWM_W-1:0]   brightness,
  output logic [LED_NUM-1:0] led
);

  localparam int MAX_LVL = max_level(LED_NUM, SEG);
  localparam int LVL_W   = level_width(MAX_LVL);
  localparam logic [31:0] MAX_EXT = 32'(MAX_LVL);

  state_t             state, state_nxt;
  logic [LVL_W-1:0]   disp_lvl, disp_nxt;
  logic               blink_phase, phase_nxt;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               ramp_tick, blink_tick, blink_en, pwm_on, alarm;
  logic [31:0]        level_ext, disp_ext;
  logic [LED_NUM-1:0] mask, bar_src;

  // Both sides widened to 32 bits so an over-range request can never alias into range.
  assign level_ext = 32'(level);
  assign disp_ext  = 32'(disp_lvl);
  assign alarm     = level_ext > MAX_EXT;
  assign blink_en  = (state == S_BLINK);

  tick_gen #(.DIV(RAMP_DIV)) u_ramp_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .tick  (ramp_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (blink_en),
    .tick  (blink_tick)
  );

  // Next-state logic: alarm has priority over any ramp step taken in the same cycle.
  always_comb begin
    state_nxt = state;
    disp_nxt  = disp_lvl;
    phase_nxt = blink_phase;
    case (state)
      S_STEADY: begin
        if (alarm) begin
          state_nxt = S_BLINK;
          phase_nxt = 1'b1;
        end else if (level_ext != disp_ext) begin
          state_nxt = S_RAMP;
        end
      end
      S_RAMP: begin
        if (alarm) begin
          state_nxt = S_BLINK;
          phase_nxt = 1'b1;
        end else if (ramp_tick) begin
          if (level_ext > disp_ext) begin
            disp_nxt = disp_lvl + LVL_W'(1);
          end else if (level_ext < disp_ext) begin
            disp_nxt = disp_lvl - LVL_W'(1);
          end
          if (32'(disp_nxt) == level_ext) begin
            state_nxt = S_STEADY;
          end
        end
      end
      S_BLINK: begin
        if (alarm) begin
          if (blink_tick) begin
            phase_nxt = ~blink_phase;
          end
        end else begin
          // Leave the alarm from a full bar so a lower request fades down.
          disp_nxt  = LVL_W'(MAX_LVL);
          state_nxt = (level_ext == MAX_EXT) ? S_STEADY : S_RAMP;
        end
      end
      default: begin
        state_nxt = S_STEADY;
      end
    endcase
  end

  // Thermometer mask: the lowest disp_lvl*SEG LEDs lit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      mask[i] = (32'(i) < disp_ext * 32'(SEG));
    end
  end

  assign pwm_on  = (&brightness) | (pwm_cnt < brightness);
  assign bar_src = blink_en ? {LED_NUM{blink_phase}} : mask;

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_STEADY;
      disp_lvl    <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_nxt;
      disp_lvl    <= disp_nxt;
      blink_phase <= phase_nxt;
    end
  end

  // PWM counter and registered LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led     <= bar_src & {LED_NUM{pwm_on}};
    end
  end

endmodule
